// File: rtl/pkg_ili9341.sv
// Shared types and default sizing for the ILI9341 SPI path.
package pkg_ili9341;

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, DONE} spi_state_t;

  localparam int SPI_DATA_W_DEF  = 8;
  localparam int SPI_CLK_DIV_DEF = 2;

endpackage

// File: rtl/spi_sclk_gen.sv
// SPI clock generator: registered sclk toggling every CLK_DIV cycles while run is high.
// clear forces sclk low and restarts the half-period count; rise_tick is suppressed under clear.
module spi_sclk_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic clear,
  output logic half_tick,
  output logic rise_tick,
  output logic fall_tick,
  output logic sclk
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] cnt;

  assign half_tick = run && (cnt == CW'(CLK_DIV - 1));
  assign rise_tick = half_tick && !sclk && !clear;
  assign fall_tick = half_tick && sclk;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      sclk <= 1'b0;
    end else if (!run || clear) begin
      cnt  <= '0;
      sclk <= 1'b0;
    end else if (half_tick) begin
      cnt  <= '0;
      sclk <= ~sclk;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/spi_master_ctrl.sv
// SPI mode-0 master, MSB first, one DATA_W word per send; optional miso capture under SPI_MISO_RX_EN.
// Latency: done pulses CLK_DIV*(2*DATA_W+1) clk edges after the accept edge.
// Backpressure: send is taken only in IDLE; requests while busy are dropped, not queued.
module spi_master_ctrl
  import pkg_ili9341::*;
#(
  parameter int DATA_W  = SPI_DATA_W_DEF,
  parameter int CLK_DIV = SPI_CLK_DIV_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              send,
  input  logic [DATA_W-1:0] data_in,
  input  logic              dc_in,
  input  logic              hold_cs,
  output logic              busy,
  output logic              done,
  output logic              cs_n,
  output logic              dc,
  output logic              sclk,
  output logic              mosi
`ifdef SPI_MISO_RX_EN
  ,
  input  logic              miso,
  output logic [DATA_W-1:0] rx_data
`endif
);

  localparam int BW = $clog2(DATA_W + 1);

  spi_state_t        state;
  logic [BW-1:0]     bit_cnt;
  logic [DATA_W-1:0] tx_sr;
  logic [DATA_W-1:0] tx_next;
  logic              hold_q;
  logic              run, clear;
  logic              half_tick, rise_tick, fall_tick;

  // SETUP is the leading low half-period, so the generator runs through both states.
  assign run     = (state == SETUP) || (state == SHIFT);
  // End of the trailing low half-period once every bit has had its rising edge.
  assign clear   = (state == SHIFT) && half_tick && !sclk && (bit_cnt == '0);
  assign tx_next = tx_sr << 1;

  spi_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk_gen (
    .clk       (clk),
    .rst       (rst),
    .run       (run),
    .clear     (clear),
    .half_tick (half_tick),
    .rise_tick (rise_tick),
    .fall_tick (fall_tick),
    .sclk      (sclk)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      bit_cnt <= '0;
      tx_sr   <= '0;
      hold_q  <= 1'b0;
      cs_n    <= 1'b1;
      mosi    <= 1'b0;
      dc      <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (send) begin
            state   <= SETUP;
            tx_sr   <= data_in;
            mosi    <= data_in[DATA_W-1];
            dc      <= dc_in;
            hold_q  <= hold_cs;
            bit_cnt <= BW'(DATA_W);
            cs_n    <= 1'b0;
            busy    <= 1'b1;
          end
        end
        SETUP: begin
          if (rise_tick) begin
            bit_cnt <= bit_cnt - 1'b1;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          if (clear) begin
            state <= DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
            cs_n  <= hold_q ? 1'b0 : 1'b1;
          end else if (rise_tick) begin
            bit_cnt <= bit_cnt - 1'b1;
          end else if (fall_tick && (bit_cnt != '0)) begin
            tx_sr <= tx_next;
            mosi  <= tx_next[DATA_W-1];
          end
        end
        DONE: begin
          done  <= 1'b0;
          mosi  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SPI_MISO_RX_EN
  logic [DATA_W-1:0] rx_sr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_sr   <= '0;
      rx_data <= '0;
    end else begin
      if (rise_tick) rx_sr <= (rx_sr << 1) | DATA_W'(miso);
      if (clear) rx_data <= rx_sr;
    end
  end
`endif

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Directed bench for spi_master_ctrl: one 8-bit/div-2 instance and one 16-bit/div-1 instance.
module tb_spi_master_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       send = 1'b0, dc_in = 1'b0, hold_cs = 1'b0;
  logic [7:0] data_in = '0;
  logic       busy, done, cs_n, dc, sclk, mosi;

  logic        b_send = 1'b0, b_dc_in = 1'b0, b_hold_cs = 1'b0;
  logic [15:0] b_data_in = '0;
  logic        b_busy, b_done, b_cs_n, b_dc, b_sclk, b_mosi;

`ifdef SPI_MISO_RX_EN
  logic [7:0]  rx_data;
  logic [15:0] b_rx_data;
  logic        b_miso = 1'b0;
`endif

  spi_master_ctrl #(.DATA_W(8), .CLK_DIV(2)) dut (
    .clk(clk), .rst(rst), .send(send), .data_in(data_in), .dc_in(dc_in), .hold_cs(hold_cs),
    .busy(busy), .done(done), .cs_n(cs_n), .dc(dc), .sclk(sclk), .mosi(mosi)
`ifdef SPI_MISO_RX_EN
    , .miso(mosi), .rx_data(rx_data)
`endif
  );

  spi_master_ctrl #(.DATA_W(16), .CLK_DIV(1)) dut_b (
    .clk(clk), .rst(rst), .send(b_send), .data_in(b_data_in), .dc_in(b_dc_in), .hold_cs(b_hold_cs),
    .busy(b_busy), .done(b_done), .cs_n(b_cs_n), .dc(b_dc), .sclk(b_sclk), .mosi(b_mosi)
`ifdef SPI_MISO_RX_EN
    , .miso(b_miso), .rx_data(b_rx_data)
`endif
  );

  int errors = 0;
  int checks = 0;

  int r_done, r_rise, r_first, r_last, r_cshi, r_dcchg, r_bsylo;
  logic [7:0] r_bits;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Edge numbers are counted from the accept edge (edge 0).
  task automatic xfer(input logic [7:0] d, input logic dci, input logic hold, input logic keep,
                      output int done_at, output int n_rise, output int first_rise,
                      output int last_rise, output int cs_hi, output int dc_chg,
                      output int bsy_lo, output logic [7:0] bits);
    logic prev;
    logic acc;
    done_at = -1; n_rise = 0; first_rise = -1; last_rise = -1;
    cs_hi = 0; dc_chg = 0; bsy_lo = 0; bits = '0; acc = 1'b0;
    data_in = d; dc_in = dci; hold_cs = hold; send = 1'b1;
    for (int i = 0; i < 4 && !acc; i++) begin
      step();
      acc = busy;
    end
    if (!keep) send = 1'b0;
    data_in = ~d; dc_in = ~dci; hold_cs = ~hold;
    prev = sclk;
    if (acc) begin
      for (int k = 1; k <= 60; k++) begin
        step();
        if (cs_n) cs_hi++;
        if (dc !== dci) dc_chg++;
        if (sclk && !prev) begin
          n_rise++;
          bits = {bits[6:0], mosi};
          if (first_rise < 0) first_rise = k;
          last_rise = k;
        end
        prev = sclk;
        if (done) begin
          done_at = k;
          break;
        end
        if (!busy) bsy_lo++;
      end
    end
    send = 1'b0;
  endtask

  initial begin
    int extra;
    int rises;
    int b_done_at, b_rise, b_first, b_last;
    logic [15:0] b_bits;
    logic prev;

    // Reset state
    step(); step();
    chk("rst_cs_n", cs_n, 1); chk("rst_sclk", sclk, 0); chk("rst_mosi", mosi, 0);
    chk("rst_dc", dc, 0); chk("rst_busy", busy, 0); chk("rst_done", done, 0);
`ifdef SPI_MISO_RX_EN
    chk("rst_rx_data", rx_data, 0);
`endif
    #2 rst = 1'b0;
    step();

    // 1: single word A5, dc=1
    xfer(8'hA5, 1'b1, 1'b0, 1'b0, r_done, r_rise, r_first, r_last, r_cshi, r_dcchg, r_bsylo, r_bits);
    chk("t1_done_edge", r_done, 34); chk("t1_rises", r_rise, 8); chk("t1_bits", r_bits, 8'hA5);
    chk("t1_first_rise", r_first, 2); chk("t1_last_rise", r_last, 30);
    chk("t1_cs_hi", r_cshi, 1); chk("t1_dc_stable", r_dcchg, 0); chk("t1_busy_gap", r_bsylo, 0);
    chk("t1_done_sclk", sclk, 0); chk("t1_done_busy", busy, 0); chk("t1_done_cs_n", cs_n, 1);
    step();
    chk("t1_idle_done", done, 0); chk("t1_idle_mosi", mosi, 0); chk("t1_idle_cs_n", cs_n, 1);
    chk("t1_idle_dc", dc, 1);

    // 2: burst 2C (hold) then 00 one clk after done
    xfer(8'h2C, 1'b0, 1'b1, 1'b0, r_done, r_rise, r_first, r_last, r_cshi, r_dcchg, r_bsylo, r_bits);
    chk("t2a_done_edge", r_done, 34); chk("t2a_bits", r_bits, 8'h2C); chk("t2a_cs_hi", r_cshi, 0);
    chk("t2a_dc_stable", r_dcchg, 0); chk("t2a_done_cs_n", cs_n, 0);
    step();
    chk("t2_idle_cs_n", cs_n, 0); chk("t2_idle_busy", busy, 0);
    xfer(8'h00, 1'b1, 1'b0, 1'b0, r_done, r_rise, r_first, r_last, r_cshi, r_dcchg, r_bsylo, r_bits);
    chk("t2b_done_edge", r_done, 34); chk("t2b_bits", r_bits, 8'h00); chk("t2b_rises", r_rise, 8);
    chk("t2b_cs_hi", r_cshi, 1); chk("t2b_done_cs_n", cs_n, 1); chk("t2b_dc", dc, 1);
    step();

    // 3: send held high while busy
    xfer(8'hC3, 1'b0, 1'b0, 1'b1, r_done, r_rise, r_first, r_last, r_cshi, r_dcchg, r_bsylo, r_bits);
    chk("t3_done_edge", r_done, 34); chk("t3_rises", r_rise, 8); chk("t3_bits", r_bits, 8'hC3);
    extra = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (done) extra++;
    end
    chk("t3_extra_done", extra, 0); chk("t3_idle_busy", busy, 0);

    // 4: reset at the 4th sclk rise
    data_in = 8'hF0; dc_in = 1'b1; hold_cs = 1'b1; send = 1'b1;
    step();
    send = 1'b0;
    rises = 0;
    prev = sclk;
    for (int i = 0; i < 40 && rises < 4; i++) begin
      step();
      if (sclk && !prev) rises++;
      prev = sclk;
    end
    chk("t4_reached_rise4", rises, 4);
    rst = 1'b1;
    #1;
    chk("t4_rst_cs_n", cs_n, 1); chk("t4_rst_sclk", sclk, 0); chk("t4_rst_busy", busy, 0);
    chk("t4_rst_mosi", mosi, 0); chk("t4_rst_dc", dc, 0);
    #2 rst = 1'b0;
    step();
    xfer(8'h5A, 1'b1, 1'b0, 1'b0, r_done, r_rise, r_first, r_last, r_cshi, r_dcchg, r_bsylo, r_bits);
    chk("t4_done_edge", r_done, 34); chk("t4_rises", r_rise, 8); chk("t4_bits", r_bits, 8'h5A);
    chk("t4_cs_hi", r_cshi, 1);
    step();

    // 5: DATA_W=16, CLK_DIV=1, 8001
    b_data_in = 16'h8001; b_send = 1'b1;
    step();
    b_send = 1'b0; b_data_in = 16'h0000;
    chk("t5_accept_busy", b_busy, 1); chk("t5_accept_cs_n", b_cs_n, 0);
    b_done_at = -1; b_rise = 0; b_first = -1; b_last = -1; b_bits = '0;
    prev = b_sclk;
    for (int k = 1; k <= 50; k++) begin
      step();
      if (b_sclk && !prev) begin
        b_rise++;
        b_bits = {b_bits[14:0], b_mosi};
        if (b_first < 0) b_first = k;
        b_last = k;
      end
      prev = b_sclk;
      if (b_done) begin
        b_done_at = k;
        break;
      end
    end
    chk("t5_done_edge", b_done_at, 33); chk("t5_rises", b_rise, 16); chk("t5_bits", b_bits, 16'h8001);
    chk("t5_first_rise", b_first, 1); chk("t5_last_rise", b_last, 31); chk("t5_done_cs_n", b_cs_n, 1);

`ifdef SPI_MISO_RX_EN
    // 6: miso looped back from mosi
    step();
    xfer(8'h3C, 1'b0, 1'b0, 1'b0, r_done, r_rise, r_first, r_last, r_cshi, r_dcchg, r_bsylo, r_bits);
    chk("t6_done_edge", r_done, 34); chk("t6_rx_data", rx_data, 8'h3C);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
